frame_sequencer: RTL and testbench

//  Game frame controller: owns a programmable tick prescaler (50 Hz by default) and, on each

---
 rtl/frame_sequencer_if.sv | 28 ++
 rtl/frame_sequencer.sv | 115 +++++++++++
 tb/tb_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Frame sequencer control/handshake bundle: run/step/config inputs, the phase
// start/done handshake, and frame status outputs.
interface frame_sequencer_if #(
   parameter int CNT_W  = 20,
   parameter int FCNT_W = 16
);
   logic              run;
   logic              step;
   logic [CNT_W-1:0]  cfg_period;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [2:0]        phase_start;
   logic [2:0]        phase_done;
   logic              frame_tick;
   logic              busy;
   logic              overrun;
   logic [FCNT_W-1:0] frame_count;

   modport master (
      output run, step, cfg_period, cfg_valid, phase_done,
      input  cfg_ready, phase_start, frame_tick, busy, overrun, frame_count
   );

   modport slave (
      input  run, step, cfg_period, cfg_valid, phase_done,
      output cfg_ready, phase_start, frame_tick, busy, overrun, frame_count
   );
endinterface

// File: rtl/frame_sequencer.sv
// Game frame controller: a tick prescaler that launches an input/update/draw
// phase sequence per tick via start/done handshakes, with pause, step and overrun.
module frame_sequencer #(
   parameter int               CNT_W          = 20,
   parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 20'h7A120,
   parameter int               FCNT_W         = 16
) (
   input  logic                 CLK,
   input  logic                 reset,
   frame_sequencer_if.slave     bus,
   output logic [2:0]           state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_PH0  = 3'd2,
      ST_PH1  = 3'd3,
      ST_PH2  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0]  MIN_PERIOD = 2;
   localparam logic [CNT_W-1:0]  ONE_C      = 1;
   localparam logic [FCNT_W-1:0] ONE_F      = 1;
   localparam logic [CNT_W-1:0]  RST_PERIOD =
      (DEFAULT_PERIOD < MIN_PERIOD) ? MIN_PERIOD : DEFAULT_PERIOD;

   state_t             state_q, state_d;
   logic               first_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   period_q;
   logic               tick_q;
   logic               overrun_q;
   logic [FCNT_W-1:0]  fcnt_q;
   logic               tc;
   logic               busy;
   logic               cfg_ready;
   logic               cfg_accept;
   logic               frame_done;
   logic [2:0]         start;

   assign tc         = bus.run && (cnt_q == period_q);
   assign busy       = (state_q == ST_PH0) || (state_q == ST_PH1) || (state_q == ST_PH2);
   // Config handshake: a word transfers on any edge where cfg_valid and cfg_ready
   // are both high; cfg_ready is only offered while idle and paused.
   assign cfg_ready  = (state_q == ST_IDLE) && !bus.run;
   assign cfg_accept = bus.cfg_valid && cfg_ready;

   always_comb begin
      state_d    = state_q;
      frame_done = 1'b0;
      start      = 3'b000;
      case (state_q)
         ST_IDLE: begin
            if (bus.run)       state_d = ST_WAIT;
            else if (bus.step) state_d = ST_PH0;
         end
         ST_WAIT: begin
            if (!bus.run) state_d = ST_IDLE;
            else if (tc)  state_d = ST_PH0;
         end
         // Done during the start cycle is ignored, so a level-style done left
         // high from the previous phase cannot skip this one.
         ST_PH0: begin
            start[0] = first_q;
            if (!first_q && bus.phase_done[0]) state_d = ST_PH1;
         end
         ST_PH1: begin
            start[1] = first_q;
            if (!first_q && bus.phase_done[1]) state_d = ST_PH2;
         end
         ST_PH2: begin
            start[2] = first_q;
            if (!first_q && bus.phase_done[2]) begin
               frame_done = 1'b1;
               state_d    = bus.run ? ST_WAIT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         first_q   <= 1'b0;
         cnt_q     <= '0;
         period_q  <= RST_PERIOD;
         tick_q    <= 1'b0;
         overrun_q <= 1'b0;
         fcnt_q    <= '0;
      end else begin
         state_q <= state_d;
         first_q <= (state_d != state_q);
         tick_q  <= tc;
         if (cfg_accept || !bus.run || tc) cnt_q <= '0;
         else                              cnt_q <= cnt_q + ONE_C;
         if (cfg_accept)
            period_q <= (bus.cfg_period < MIN_PERIOD) ? MIN_PERIOD : bus.cfg_period;
         // A tick landing on a busy cycle (including the final done edge) is dropped.
         if (cfg_accept)     overrun_q <= 1'b0;
         else if (tc && busy) overrun_q <= 1'b1;
         if (frame_done) fcnt_q <= fcnt_q + ONE_F;
      end
   end

   assign bus.cfg_ready   = cfg_ready;
   assign bus.phase_start = start;
   assign bus.frame_tick  = tick_q;
   assign bus.busy        = busy;
   assign bus.overrun     = overrun_q;
   assign bus.frame_count = fcnt_q;
   assign state_dbg       = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: phase starts are scoreboarded against an
// expected queue while the main thread checks ticks, overrun, step and config.
module tb_frame_sequencer;
  localparam int CW = 20;
  localparam int FW = 8;   // narrow frame counter so the wrap is reachable quickly
  localparam int W  = FW + 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PH1  = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_sequencer_if #(.CNT_W(CW), .FCNT_W(FW)) bus ();
  logic [2:0] state_dbg;

  frame_sequencer #(.CNT_W(CW), .DEFAULT_PERIOD(20'h7A120), .FCNT_W(FW)) dut (
    .CLK(clk),
    .reset(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [2:0] hold = 3'b000;
  logic [2:0] pend = 3'b000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [FW-1:0] fc);
    exp_q.push_back({fc, 3'b001});
    exp_q.push_back({fc, 3'b010});
    exp_q.push_back({fc, 3'b100});
  endtask

  task automatic wait_fc(input logic [FW-1:0] t, input int budget, input string name);
    int n = 0;
    while (bus.frame_count !== t && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.frame_count), 32'(t));
  endtask

  task automatic wait_tick(input int budget, input string name, output int c);
    int n = 0;
    @(negedge clk);
    while (bus.frame_tick !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.frame_tick), 32'd1);
    c = cyc;
  endtask

  task automatic config_period(input logic [CW-1:0] p);
    bus.cfg_period = p;
    bus.cfg_valid  = 1'b1;
    cycles(1);
    bus.cfg_valid  = 1'b0;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    cycles(1);
    bus.step = 1'b0;
  endtask

  // Scoreboard monitor: every phase_start pulse must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.phase_start != 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got start=%b fc=%0d expected none", bus.phase_start, bus.frame_count);
        end else begin
          mon_e = exp_q.pop_front();
          check("phase_start_seq", 32'({bus.frame_count, bus.phase_start}), 32'(mon_e));
        end
      end
    end
  end

  // Phase responder: returns done one cycle after each start unless that phase is held.
  initial begin
    bus.phase_done = 3'b000;
    forever begin
      @(negedge clk);
      bus.phase_done = 3'b000;
      if (!rst_n) pend = 3'b000;
      else begin
        if (pend != 3'b000 && (pend & hold) == 3'b000) begin
          bus.phase_done = pend;
          pend = 3'b000;
        end
        if (bus.phase_start != 3'b000) pend = bus.phase_start;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t1, t2, t3;
    bus.run = 1'b0;
    bus.step = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_valid = 1'b0;

    // Reset state
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    check("rst_phase_start", 32'(bus.phase_start), 32'd0);
    check("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_period", 32'(dut.period_q), 32'h7A120);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // Free-running frames at period 10: tick every 11 cycles
    config_period(20'd10);
    check("cfg10_period", 32'(dut.period_q), 32'd10);
    push_frame(8'd0);
    push_frame(8'd1);
    push_frame(8'd2);
    bus.run = 1'b1;
    wait_tick(40, "p10_tick1", t1);
    wait_tick(40, "p10_tick2", t2);
    check("p10_gap1", 32'(t2 - t1), 32'd11);
    wait_tick(40, "p10_tick3", t3);
    check("p10_gap2", 32'(t3 - t2), 32'd11);
    wait_fc(8'd3, 20, "p10_frames");
    bus.run = 1'b0;
    check("p10_no_overrun", 32'(bus.overrun), 32'd0);

    // Stalled update phase: ticks dropped, overrun sticky, frame still completes
    push_frame(8'd3);
    hold = 3'b010;
    bus.run = 1'b1;
    cycles(40);
    check("stall_overrun", 32'(bus.overrun), 32'd1);
    check("stall_busy", 32'(bus.busy), 32'd1);
    check("stall_state", 32'(state_dbg), 32'(ST_PH1));
    check("stall_fc", 32'(bus.frame_count), 32'd3);
    hold = 3'b000;
    bus.run = 1'b0;
    wait_fc(8'd4, 20, "stall_release_fc");
    cycles(2);
    check("stall_idle_busy", 32'(bus.busy), 32'd0);
    check("stall_sticky", 32'(bus.overrun), 32'd1);
    check("stall_cfg_ready", 32'(bus.cfg_ready), 32'd1);

    // Single step while paused; a second step mid-frame is ignored
    push_frame(8'd4);
    pulse_step();
    cycles(2);
    check("step_busy", 32'(bus.busy), 32'd1);
    pulse_step();
    wait_fc(8'd5, 20, "step_fc");
    cycles(3);
    check("step_idle_busy", 32'(bus.busy), 32'd0);
    check("step_idle_state", 32'(state_dbg), 32'(ST_IDLE));
    check("step_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("step_fc_stable", 32'(bus.frame_count), 32'd5);

    // Period 0 clamps to 2; config refused while running; tick on final done dropped
    config_period(20'd0);
    check("clamp_period", 32'(dut.period_q), 32'd2);
    check("cfg_clears_overrun", 32'(bus.overrun), 32'd0);
    push_frame(8'd5);
    push_frame(8'd6);
    bus.run = 1'b1;
    wait_tick(20, "p2_tick1", t1);
    wait_tick(20, "p2_tick2", t2);
    check("p2_gap", 32'(t2 - t1), 32'd3);
    bus.cfg_period = 20'd7;
    bus.cfg_valid = 1'b1;
    check("run_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    cycles(1);
    bus.cfg_valid = 1'b0;
    check("run_cfg_rejected", 32'(dut.period_q), 32'd2);
    wait_fc(8'd7, 60, "p2_frames");
    bus.run = 1'b0;
    check("p2_overrun", 32'(bus.overrun), 32'd1);
    cycles(3);

    // Reset in the middle of the update phase
    exp_q.push_back({8'd7, 3'b001});
    exp_q.push_back({8'd7, 3'b010});
    hold = 3'b010;
    pulse_step();
    cycles(5);
    check("midrst_pre_state", 32'(state_dbg), 32'(ST_PH1));
    rst_n = 1'b0;
    cycles(1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("midrst_start", 32'(bus.phase_start), 32'd0);
    check("midrst_fc", 32'(bus.frame_count), 32'd0);
    rst_n = 1'b1;
    hold = 3'b000;
    cycles(2);
    check("midrst_period", 32'(dut.period_q), 32'h7A120);
    check("midrst_start_idle", 32'(bus.phase_start), 32'd0);

    // Frame counter wrap
    config_period(20'd10);
    for (int i = 0; i < 256; i++) push_frame(i[FW-1:0]);
    bus.run = 1'b1;
    wait_fc(8'hFF, 3500, "wrap_max");
    wait_fc(8'h00, 20, "wrap_zero");
    bus.run = 1'b0;
    cycles(5);
    check("wrap_fc_after", 32'(bus.frame_count), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
